// File: rtl/uart_ram_dumper_if.sv
// RAM read port and UART TX byte stream used by the RAM dumper.
// The dumper is the master: it drives the read strobe/address and the TX byte.
interface uart_ram_dumper_if #(
   parameter int ADDR_LEN = 14,
   parameter int XLEN     = 32
);
   logic                ram_rd_en;
   logic [ADDR_LEN-1:0] ram_addr;
   logic [XLEN-1:0]     ram_rd_data;
   logic                uart_tx_valid;
   logic [7:0]          uart_tx_data;
   logic                uart_tx_ready;

   modport master (
      output ram_rd_en, ram_addr, uart_tx_valid, uart_tx_data,
      input  ram_rd_data, uart_tx_ready
   );

   modport slave (
      input  ram_rd_en, ram_addr, uart_tx_valid, uart_tx_data,
      output ram_rd_data, uart_tx_ready
   );
endinterface

// File: rtl/uart_ram_dumper.sv
// Reads a range of RAM words and streams them to the UART TX, little-endian byte order.
// Every output is a register or a decode of the state register.
module uart_ram_dumper #(
   parameter int ADDR_LEN = 14,
   parameter int XLEN     = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dump_start_i,
   input  logic [ADDR_LEN-1:0] dump_addr_i,
   input  logic [ADDR_LEN:0]   dump_words_i,
   input  logic                dump_abort_i,
   output logic                busy_o,
   output logic                done_o,
   uart_ram_dumper_if.master   bus
);
   localparam int BYTES = XLEN / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int CNT_W = ADDR_LEN + 1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_WAIT = 3'd2,
      ST_SEND = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_LEN-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]    remain_q, remain_d;
   logic [XLEN-1:0]     shreg_q, shreg_d;
   logic [IDX_W-1:0]    idx_q, idx_d;

   // State and datapath registers; synchronous reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         shreg_q  <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         shreg_q  <= shreg_d;
         idx_q    <= idx_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      shreg_d  = shreg_q;
      idx_d    = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (dump_abort_i) begin
               state_d = ST_IDLE;
            end else if (dump_start_i) begin
               if (dump_words_i == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_READ;
                  addr_d   = dump_addr_i;
                  remain_d = dump_words_i;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: state_d = ST_WAIT;
         ST_WAIT: begin
            shreg_d = bus.ram_rd_data;
            idx_d   = '0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (!bus.uart_tx_ready) begin
               state_d = ST_SEND;
            end else if (idx_q != IDX_W'(BYTES - 1)) begin
               shreg_d = shreg_q >> 4'd8;
               idx_d   = idx_q + IDX_W'(1);
            end else begin
               remain_d = remain_q - CNT_W'(1);
               if (remain_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
               end else begin
                  // Address wraps naturally at 2^ADDR_LEN.
                  addr_d  = addr_q + ADDR_LEN'(1);
                  state_d = ST_READ;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if ((state_q != ST_IDLE) && dump_abort_i) begin
         state_d = ST_IDLE;
      end else begin
         state_d = state_d;
      end
   end

   assign busy_o            = (state_q != ST_IDLE);
   assign done_o            = (state_q == ST_DONE);
   assign bus.ram_rd_en     = (state_q == ST_READ);
   assign bus.ram_addr      = addr_q;
   assign bus.uart_tx_valid = (state_q == ST_SEND);
   assign bus.uart_tx_data  = shreg_q[7:0];
endmodule
